fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_pkg.sv | 6 +
 rtl/uart_pkg.sv | 15 +
 rtl/uart_baud_counter.sv | 29 ++
 rtl/fifo_uart_tx.sv | 112 +++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO parameters for the producer side of the UART transmit path.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;

endpackage

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states and default bit timing.
package uart_pkg;

    // 100 MHz system clock divided down to 115200 baud
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;
    localparam int unsigned BAUD_CNT_W           = 16;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } uart_tx_state_e;

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period down-counter: reload on each bit boundary, o_done marks the last cycle of a bit.
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam logic [BAUD_CNT_W-1:0] RELOAD = BAUD_CNT_W'(CLKS_PER_BIT - 1);

    logic [BAUD_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one FIFO word per frame and sends it 8N1-style, LSB first.
module fifo_uart_tx
    import fifo_pkg::*, uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $fatal(1, "fifo_uart_tx: CLKS_PER_BIT must be in 2..65535");
    end

    uart_tx_state_e        r_state, w_state_next;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_next;
    logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_next;
    logic                  r_tx, w_tx_next;
    logic                  w_pop;
    logic                  w_load;
    logic                  w_bit_done;

    // rst_n is in the term so the FIFO is never popped while the transmitter is held in reset
    assign w_pop      = (r_state == StIdle) && tx_en && !fifo_empty && rst_n;
    assign fifo_rd_en = w_pop;
    assign tx         = r_tx;
    assign busy       = (r_state != StIdle);

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst_n (rst_n),
        .i_load(w_load),
        .o_done(w_bit_done)
    );

    always_comb begin
        w_state_next   = r_state;
        w_shift_next   = r_shift;
        w_bit_cnt_next = r_bit_cnt;
        w_tx_next      = r_tx;
        w_load         = 1'b0;

        unique case (r_state)
            StIdle: begin
                w_tx_next = 1'b1;
                if (w_pop) begin
                    w_state_next   = StStart;
                    w_shift_next   = fifo_rd_data;
                    w_bit_cnt_next = '0;
                    w_tx_next      = 1'b0;
                    w_load         = 1'b1;
                end
            end
            StStart: begin
                if (w_bit_done) begin
                    w_state_next   = StData;
                    w_tx_next      = r_shift[0];
                    w_shift_next   = r_shift >> 1;
                    w_bit_cnt_next = '0;
                    w_load         = 1'b1;
                end
            end
            StData: begin
                if (w_bit_done) begin
                    w_load         = 1'b1;
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        w_state_next = StStop;
                        w_tx_next    = 1'b1;
                    end else begin
                        w_tx_next    = r_shift[0];
                        w_shift_next = r_shift >> 1;
                    end
                end
            end
            StStop: begin
                // No reload here: the counter parks at zero while idle
                if (w_bit_done) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= StIdle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_tx      <= w_tx_next;
        end
    end

endmodule
